// File: rtl/agendador_pkg.sv
`default_nettype none
// ============================================================================
// Module      : agendador_pkg
// Description : Shared constants and types for the coffee-machine scheduler:
//               machine state codes and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package agendador_pkg;

  // Coffee-machine state codes as reported on mach_state
  localparam logic [3:0] MAQ_IDLE     = 4'd1;
  localparam logic [3:0] MAQ_EXTRACAO = 4'd9;
  localparam logic [3:0] MAQ_MIN      = 4'd1;
  localparam logic [3:0] MAQ_MAX      = 4'd9;

  // Controller states, explicitly encoded
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } ctrl_state_t;

  // True when the machine reports a code inside its legal range
  function automatic logic maq_legal(input logic [3:0] s);
    return (s >= MAQ_MIN) && (s <= MAQ_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/agendador_cafe_arbitro_rr.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_rr
// Description : Combinational round-robin picker. Searches the request vector
//               circularly starting just after the pointer and returns the
//               first hit as a one-hot grant plus its index.
// Revision    : 1.0 - initial release
// ============================================================================
module arbitro_rr #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  logic            r_found_unused;
  int              w_cand;
  logic            w_found;

  // Circular scan: candidates ptr+1, ptr+2, ... wrapping, first set bit wins
  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_cand = (int'(ptr) + i) % N_REQ;
      if (!w_found && req[IDX_W'(w_cand)]) begin
        w_found                = 1'b1;
        gnt[IDX_W'(w_cand)]    = 1'b1;
        idx                    = IDX_W'(w_cand);
      end
    end
  end

  assign r_found_unused = w_found;

endmodule
`default_nettype wire

// File: rtl/agendador_cafe.sv
`default_nettype none
// ============================================================================
// Module      : agendador_cafe
// Description : Round-robin scheduler sharing one coffee machine among
//               N_REQ requesters. Grants the machine, pulses its start input,
//               follows its state code to completion and returns a done
//               pulse to the served requester. A watchdog catches stuck or
//               illegal machine sequences and parks the controller in fault.
// Revision    : 1.0 - initial release
// ============================================================================
module agendador_cafe
  import agendador_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] done,
  output logic             mach_start,
  input  logic [3:0]       mach_state,
  output logic             busy,
  output logic             fault,
  input  logic             fault_clr,
  output logic [CNT_W-1:0] served_cnt
);

  localparam int c_IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // One extra code so TIMEOUT+1 always fits, even when TIMEOUT+1 is a power of two
  localparam int c_WD_W  = $clog2(TIMEOUT + 2);

  localparam logic [c_WD_W-1:0]  c_WD_SAT       = c_WD_W'(TIMEOUT + 1);
  // In START the count holds cycles already spent; the last allowed cycle is TIMEOUT-1
  localparam logic [c_WD_W-1:0]  c_WD_START_LIM = c_WD_W'(TIMEOUT - 1);
  // In RUN, cycles spent including the current one exceed TIMEOUT when count >= TIMEOUT
  localparam logic [c_WD_W-1:0]  c_WD_RUN_LIM   = c_WD_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]   c_CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [c_IDX_W-1:0] c_PTR_RST      = c_IDX_W'(N_REQ - 1);

  ctrl_state_t          r_state;
  ctrl_state_t          w_next;
  logic [N_REQ-1:0]     r_grant;
  logic [c_IDX_W-1:0]   r_gidx;
  logic [c_IDX_W-1:0]   r_ptr;
  logic                 r_seen_ext;
  logic [c_WD_W-1:0]    r_wdog;
  logic [CNT_W-1:0]     r_served;
  logic [N_REQ-1:0]     w_arb_gnt;
  logic [c_IDX_W-1:0]   w_arb_idx;
  logic                 w_req_any;

  assign w_req_any  = |req;
  assign grant      = r_grant;
  assign served_cnt = r_served;

  arbitro_rr #(
    .N_REQ (N_REQ),
    .IDX_W (c_IDX_W)
  ) u_arbitro (
    .req (req),
    .ptr (r_ptr),
    .gnt (w_arb_gnt),
    .idx (w_arb_idx)
  );

  // Controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decision and state-decoded outputs
  always_comb begin
    w_next     = r_state;
    mach_start = 1'b0;
    busy       = 1'b1;
    fault      = 1'b0;
    done       = '0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        // Only start a service once the machine itself reports idle
        if (w_req_any && (mach_state == MAQ_IDLE)) begin
          w_next = S_START;
        end
      end
      S_START: begin
        mach_start = 1'b1;
        if (mach_state != MAQ_IDLE) begin
          w_next = S_RUN;
        end else if (r_wdog >= c_WD_START_LIM) begin
          w_next = S_FAULT;
        end
      end
      S_RUN: begin
        if (!maq_legal(mach_state)) begin
          w_next = S_FAULT;
        end else if (mach_state == MAQ_IDLE) begin
          // Back at idle is only a completion if extraction was actually seen
          w_next = r_seen_ext ? S_DONE : S_FAULT;
        end else if (r_wdog >= c_WD_RUN_LIM) begin
          w_next = S_FAULT;
        end
      end
      S_DONE: begin
        done   = r_grant;
        w_next = S_IDLE;
      end
      S_FAULT: begin
        fault = 1'b1;
        if (fault_clr) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Grant capture at arbitration, release at completion or fault; pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= c_PTR_RST;
    end else begin
      if ((r_state == S_IDLE) && (w_next == S_START)) begin
        r_grant <= w_arb_gnt;
        r_gidx  <= w_arb_idx;
      end else if ((r_state == S_DONE) || (w_next == S_FAULT)) begin
        r_grant <= '0;
      end
      // Just-served requester becomes lowest priority next round
      if (r_state == S_DONE) begin
        r_ptr <= r_gidx;
      end
    end
  end

  // Remember that the machine passed through extraction during this service
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen_ext <= 1'b0;
    end else if (r_state != S_RUN) begin
      r_seen_ext <= 1'b0;
    end else if (mach_state == MAQ_EXTRACAO) begin
      r_seen_ext <= 1'b1;
    end
  end

  // Phase watchdog: restarts on every state change, saturates at TIMEOUT+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (w_next != r_state) begin
      r_wdog <= '0;
    end else if (r_wdog != c_WD_SAT) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  // Completed-order counter, saturating at all ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_served <= '0;
    end else if ((r_state == S_DONE) && (r_served != c_CNT_MAX)) begin
      r_served <= r_served + 1'b1;
    end
  end

endmodule
`default_nettype wire
